mem_line_responder: RTL
=======================

Name: mem_line_responder

Overview:
Memory-side responder for the wide line-fill request interface that the instruction caches drive (mem_req_valid / mem_req_ready / mem_req_addr / mem_req_rdata). It holds a word-organised backing store, assembles one full cache line per request over multiple internal beats, and returns the line with a one-cycle ready pulse. It sits between the icache variants and the program memory image in simulation and FPGA builds, with a configurable extra access latency.

Parameters:
MEM_WORDS, 16384, backing store depth in 32-bit words; power of two.
BLOCK_SIZE, 2, block size in bytes; must match the attached cache.
NUM_BLOCKS, 4, blocks per line; NUM_BLOCKS*BLOCK_SIZE must be a multiple of 4.
LATENCY, 2, extra wait cycles before fetch beats start; 0 allowed.
INIT_FILE, "", hex image loaded with $readmemh at elaboration when non-empty.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
mem_req_valid  in  1  fill request from the cache; held until ready is seen.
mem_req_ready  out  1  one-cycle pulse; mem_req_rdata is valid in that cycle.
mem_req_addr  in  32  request byte address; low log2(line bytes) bits ignored.
mem_req_rdata  out  8*BLOCK_SIZE*NUM_BLOCKS  line data; byte 0 of the line in bits [7:0].
ld_we  in  1  loader write enable.
ld_addr  in  32  loader word address (byte address >> 2); taken modulo MEM_WORDS.
ld_wdata  in  32  loader write data.

Behaviour:
- Derived values: LINE_BYTES = NUM_BLOCKS*BLOCK_SIZE, WPL = LINE_BYTES/4 (2 at defaults), LOFF = log2(LINE_BYTES).
- Reset: state IDLE, mem_req_ready=0, mem_req_rdata=0, counters=0. The storage array is not cleared.
- States:
  - IDLE: when valid=1, latch base word = mem_req_addr[31:LOFF] * WPL (mod MEM_WORDS) and clear the beat counter. Next state is WAIT when LATENCY>0, otherwise FETCH.
  - WAIT: decrement the latency counter; go to FETCH after exactly LATENCY cycles.
  - FETCH: each cycle read word (base+beat) mod MEM_WORDS into line buffer slot beat (slot k occupies bits [32k+31:32k]); after beat WPL-1, go to RESP.
  - RESP: mem_req_ready=1 and mem_req_rdata=line buffer for exactly one cycle; then HOLD.
  - HOLD: ready=0; stay until valid=0, then IDLE. A new request needs valid low for at least one cycle.
- Latency: with valid first high in cycle 0, ready is high in cycle LATENCY+WPL+1 (cycle 5 at defaults).
- Abort: valid=0 sampled in WAIT or FETCH returns to IDLE next cycle. No ready is issued and the partial line is discarded.
- mem_req_addr is sampled only in IDLE. Changes while busy are ignored.
- mem_req_rdata holds its last value outside RESP and is not cleared.
- Loader: a write occurs on any cycle with ld_we=1, regardless of state. If the same word is read by FETCH in that cycle, the read returns the old data (read-before-write); the new data is visible from the next cycle.
- Address wrap: word indices wrap modulo MEM_WORDS, including a line that straddles the top of memory.
- Reset asserted mid-transfer returns the block to IDLE next cycle with ready=0 and no pulse.

Optional Feature:
MEM_RESP_STATS_EN
- Defined: adds outputs stat_fills[31:0] and stat_aborts[31:0], both reset to 0. stat_fills increments on each RESP cycle; stat_aborts increments on each abort exit from WAIT or FETCH. Both wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Defaults. Load word 0x40=0x11223344 and word 0x41=0x55667788; hold valid with addr=0x100 -> ready high only in cycle 5, rdata=0x5566778811223344.
- LATENCY=0, same image, addr=0x104 (offset ignored) -> ready in cycle 3 with the same rdata.
- Drop valid in cycle 3 (FETCH) -> no ready pulse; a fresh request to 0x100 then completes normally. With MEM_RESP_STATS_EN: stat_aborts=1, stat_fills=1.
- Addr=(MEM_WORDS*4-8), words at MEM_WORDS-2 and MEM_WORDS-1 = 0xAAAA0000 and 0xBBBB0001 -> rdata=0xBBBB0001AAAA0000. Also cover a line whose second word wraps to word 0.
- ld_we writes word 0x41=0xDEADBEEF in the same cycle FETCH reads word 0x41 -> rdata upper word=0x55667788; a repeat request returns upper word=0xDEADBEEF.
- Assert reset in cycle 2 of a request -> ready stays 0; after release, a new request to 0x100 responds in cycle 5 with correct data.

Source files
------------

// File: rtl/mem_line_responder_if.sv
// Line-fill request bus between an instruction cache and its memory responder.
// Signals:
//   mem_req_valid  cache -> mem  fill request, held until ready is seen
//   mem_req_addr   cache -> mem  request byte address
//   mem_req_ready  mem -> cache  one-cycle pulse, rdata valid in that cycle
//   mem_req_rdata  mem -> cache  full line, byte 0 of the line in bits [7:0]
interface mem_line_responder_if #(
    parameter int unsigned LINE_W = 64
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [31:0]       mem_req_addr;
    logic [LINE_W-1:0] mem_req_rdata;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_req_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_req_rdata
    );
endinterface

// File: rtl/mem_line_responder.sv
// Memory-side responder for cache line fills. Holds a word-organised backing
// store, gathers one line per request over WPL internal read beats after
// LATENCY wait cycles, and returns it with a one-cycle ready pulse.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   bus (slave)       mem_req_valid/addr in, mem_req_ready/rdata out
//   ld_we/addr/wdata  loader word write port, address taken modulo MEM_WORDS
//   stat_fills/stat_aborts  fill and abort counters (MEM_RESP_STATS_EN only)
// Optional feature macro: MEM_RESP_STATS_EN.
module mem_line_responder #(
    parameter int unsigned MEM_WORDS  = 16384,
    parameter int unsigned BLOCK_SIZE = 2,
    parameter int unsigned NUM_BLOCKS = 4,
    parameter int unsigned LATENCY    = 2,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    mem_line_responder_if.slave bus,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0] stat_fills,
    output logic [31:0] stat_aborts
`endif
);
    localparam int unsigned LINE_BYTES = NUM_BLOCKS * BLOCK_SIZE;
    localparam int unsigned WPL        = LINE_BYTES / 4;
    localparam int unsigned LOFF       = $clog2(LINE_BYTES);
    localparam int unsigned LINE_W     = 32 * WPL;
    localparam int unsigned AW         = $clog2(MEM_WORDS);
    localparam int unsigned BW         = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int unsigned LAT_W      = $clog2(LATENCY + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_RESP,
        S_HOLD
    } state_e;

    state_e                state_q;
    logic [31:0]           mem_q [MEM_WORDS];
    logic [AW-1:0]         base_q;
    logic [AW-1:0]         base_d;
    logic [AW-1:0]         rd_idx;
    logic [31:0]           rd_word;
    logic [BW-1:0]         beat_q;
    logic [LAT_W-1:0]      lat_q;
    logic [WPL-1:0][31:0]  line_q;
    logic [WPL-1:0][31:0]  line_d;
    logic [LINE_W-1:0]     rdata_q;
    logic                  ready_q;
`ifdef MEM_RESP_STATS_EN
    logic [31:0]           fills_q;
    logic [31:0]           aborts_q;
`endif

    // First word of the line; the multiply and truncation give the modulo wrap.
    assign base_d  = AW'((bus.mem_req_addr >> LOFF) * WPL);
    assign rd_idx  = base_q + AW'(beat_q);
    assign rd_word = mem_q[rd_idx];

    // Line buffer with the current beat merged in, so the last beat can be
    // published in the same edge that enters RESP.
    always_comb begin
        line_d         = line_q;
        line_d[beat_q] = rd_word;
    end

    // Loader port; a same-cycle FETCH read sees the old word.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_q[AW'(ld_addr)] <= ld_wdata;
        end
    end

    // Request sequencer with registered ready/rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            base_q   <= '0;
            beat_q   <= '0;
            lat_q    <= '0;
            line_q   <= '0;
`ifdef MEM_RESP_STATS_EN
            fills_q  <= '0;
            aborts_q <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_req_valid) begin
                        base_q  <= base_d;
                        beat_q  <= '0;
                        lat_q   <= LAT_W'(LATENCY);
                        state_q <= (LATENCY > 0) ? S_WAIT : S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (!bus.mem_req_valid) begin
                        state_q  <= S_IDLE;
`ifdef MEM_RESP_STATS_EN
                        aborts_q <= aborts_q + 32'd1;
`endif
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                        if (lat_q == LAT_W'(1)) begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (!bus.mem_req_valid) begin
                        state_q  <= S_IDLE;
`ifdef MEM_RESP_STATS_EN
                        aborts_q <= aborts_q + 32'd1;
`endif
                    end else begin
                        line_q <= line_d;
                        beat_q <= beat_q + BW'(1);
                        if (beat_q == BW'(WPL - 1)) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            rdata_q <= line_d;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_HOLD;
`ifdef MEM_RESP_STATS_EN
                    fills_q <= fills_q + 32'd1;
`endif
                end
                S_HOLD: begin
                    // Valid must drop before the next request is accepted.
                    if (!bus.mem_req_valid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req_ready = ready_q;
    assign bus.mem_req_rdata = rdata_q;

`ifdef MEM_RESP_STATS_EN
    assign stat_fills  = fills_q;
    assign stat_aborts = aborts_q;
`endif

endmodule
